// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Grant-source encodings, FSM states, default sizing and zero-register helpers.
package rf_wb_arbiter_pkg;

    localparam int RF_WB_MAX_WAIT_DEF = 4;
    localparam int RF_WB_CNT_W_DEF    = 3;

    typedef enum logic [1:0] {
        RF_WB_GRANT_NONE = 2'b00,
        RF_WB_GRANT_P    = 2'b01,
        RF_WB_GRANT_M    = 2'b10
    } rf_wb_grant_e;

    typedef enum logic {
        RF_WB_ST_NORMAL  = 1'b0,
        RF_WB_ST_FORCE_M = 1'b1
    } rf_wb_state_e;

    localparam logic       RF_WRITE_ENABLED = 1'b1;
    localparam logic [4:0] RF_ADDR_ZERO     = 5'd0;

    // $0 is hardwired; a write to it is accepted but never reaches the file.
    function automatic logic is_zero_reg(input logic [4:0] addr);
        return addr == RF_ADDR_ZERO;
    endfunction

endpackage

// File: rtl/rf_wb_age_counter.sv
// Saturating age counter for the M writeback source.
// Counts cycles M is held off; saturates at MAX_WAIT and never wraps.
module rf_wb_age_counter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = RF_WB_MAX_WAIT_DEF,
    parameter int CNT_W    = RF_WB_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] age,
    output logic             at_limit
);

    localparam logic [CNT_W-1:0] SAT   = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WAIT - 1);

    // Age register: clear wins over increment, increment stops at saturation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            age <= '0;
        end else if (clr) begin
            age <= '0;
        end else if (inc && (age != SAT)) begin
            age <= age + 1'b1;
        end
    end

    assign at_limit = (age == LIMIT);

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter between pipeline (P) and mult/div (M) writeback.
// P has fixed priority; the age counter bounds M's wait and forces one M grant.
// Optional macro RF_WB_TRACE_EN adds a simulation trace of committed writes.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// NORMAL     | P wins if valid, otherwise M; M ages while held off
// FORCE_M    | M has waited MAX_WAIT cycles; P stalls for one M grant
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = RF_WB_MAX_WAIT_DEF,
    parameter int CNT_W    = RF_WB_CNT_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p_valid,
    output logic        p_ready,
    input  logic [4:0]  p_addr,
    input  logic [31:0] p_data,
    input  logic [31:0] p_pc,
    input  logic        m_valid,
    output logic        m_ready,
    input  logic [4:0]  m_addr,
    input  logic [31:0] m_data,
    input  logic [31:0] m_pc,
    output logic        rf_write_enable,
    output logic [4:0]  rf_write_addr,
    output logic [31:0] rf_write_data,
    output logic [31:0] rf_curr_pc,
    output logic [1:0]  grant_src
);

    rf_wb_state_e     state, state_next;
    rf_wb_grant_e     src_q;
    logic [CNT_W-1:0] age;
    logic             at_limit;
    logic             p_acc, m_acc;

    rf_wb_age_counter #(
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W)
    ) u_age (
        .clk      (clk),
        .rst      (rst),
        .inc      (m_valid & ~m_ready),
        .clr      (~m_valid | m_ready),
        .age      (age),
        .at_limit (at_limit)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RF_WB_ST_NORMAL;
        else      state <= state_next;
    end

    // Ready decode and next state; both readies held low during reset.
    always_comb begin
        p_ready    = 1'b0;
        m_ready    = 1'b0;
        state_next = state;
        if (rst) begin
            case (state)
                RF_WB_ST_NORMAL: begin
                    p_ready = p_valid;
                    m_ready = m_valid & ~p_valid;
                    if (m_valid && !m_ready && at_limit) state_next = RF_WB_ST_FORCE_M;
                end
                RF_WB_ST_FORCE_M: begin
                    m_ready    = m_valid;
                    state_next = RF_WB_ST_NORMAL;
                end
                default: state_next = RF_WB_ST_NORMAL;
            endcase
        end
    end

    assign p_acc = p_valid & p_ready;
    assign m_acc = m_valid & m_ready;

    // Output register: payload only updates on a real (non-$0) write, else holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_write_enable <= 1'b0;
            rf_write_addr   <= '0;
            rf_write_data   <= '0;
            rf_curr_pc      <= '0;
            src_q           <= RF_WB_GRANT_NONE;
        end else if (p_acc && !is_zero_reg(p_addr)) begin
            rf_write_enable <= RF_WRITE_ENABLED;
            rf_write_addr   <= p_addr;
            rf_write_data   <= p_data;
            rf_curr_pc      <= p_pc;
            src_q           <= RF_WB_GRANT_P;
        end else if (m_acc && !is_zero_reg(m_addr)) begin
            rf_write_enable <= RF_WRITE_ENABLED;
            rf_write_addr   <= m_addr;
            rf_write_data   <= m_data;
            rf_curr_pc      <= m_pc;
            src_q           <= RF_WB_GRANT_M;
        end else begin
            rf_write_enable <= 1'b0;
            src_q           <= RF_WB_GRANT_NONE;
        end
    end

    assign grant_src = src_q;

`ifdef RF_WB_TRACE_EN
    // Trace of each committed write and each forced M grant.
    always @(posedge clk) begin
        if (rst && rf_write_enable)
            $display("@%t: src=%s pc=0x%08x $%0d <= 0x%08x", $time,
                     (src_q == RF_WB_GRANT_P) ? "P" : "M",
                     rf_curr_pc, rf_write_addr, rf_write_data);
        if (rst && (state == RF_WB_ST_FORCE_M) && m_acc)
            $display("@%t: forced M grant $%0d age=%0d", $time, m_addr, age);
    end
`else
    logic unused_age;
    assign unused_age = ^age;
`endif

endmodule
